lz77_stream_encoder: RTL and testbench

//  Parametrised next-generation LZ77 encoder. Consumes a symbol stream with a ready/valid input and
//  i_last block delimiting. Emits literal or (offset,length) tokens on a ready/valid output with

---
 rtl/lz77_pkg.sv | 36 +++
 rtl/lz77_match_cam.sv | 72 +++++++
 rtl/lz77_stream_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_lz77_stream_encoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lz77_pkg
//  Purpose  : Shared types and width helpers for the LZ77 stream encoder.
//             - state_e    : encoder control states
//             - ofs_width  : bits needed for an offset 1..WIN
//             - len_width  : bits needed for a length 0..MAX_LEN
//             - buf_depth  : depth of the short-run literal buffer
//  Revision : 1.0  initial release
// ============================================================================
package lz77_pkg;

  typedef enum logic [2:0] {
    S_SCAN   = 3'd0,  // accepting symbols, extending or starting runs
    S_DRAIN  = 3'd1,  // replaying a too-short run as literals
    S_REEVAL = 3'd2,  // re-processing the symbol that broke a run
    S_FLUSH  = 3'd3,  // waiting for the block's final token to leave
    S_FIN    = 3'd4   // finish pulse, history cleared
  } state_e;

  function automatic int ofs_width(input int win);
    return $clog2(win + 1);
  endfunction

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // A run shorter than MIN_MATCH holds at most MIN_MATCH-1 symbols; keep at
  // least one entry so the array never collapses to zero size.
  function automatic int buf_depth(input int min_match);
    return (min_match > 1) ? min_match - 1 : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lz77_match_cam.sv
`default_nettype none
// ============================================================================
//  Module   : lz77_match_cam
//  Purpose  : History window and parallel comparator for the LZ77 encoder.
//             win[k] holds the symbol k+1 shifts ago; eq_o[d-1] flags that
//             the symbol d positions back equals sym_i and is part of the
//             current block. Also provides a lowest-index priority encoder
//             used to pick the shortest matching distance.
//  Ports    : clk, rst       clock, async active-high reset
//             shift_i        push sym_i into the window
//             clear_i        forget the block history (valid count -> 0)
//             sym_i          symbol under comparison
//             eq_o           per-distance equality vector (bit d-1 = dist d)
//             enc_vec_i      vector to priority-encode
//             enc_ofs_o      lowest set distance in enc_vec_i (0 if none)
//  Revision : 1.0  initial release
// ============================================================================
module lz77_match_cam #(
  parameter int DW    = 8,
  parameter int WIN   = 16,
  parameter int OFS_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [DW-1:0]    sym_i,
  output logic [WIN-1:0]   eq_o,
  input  logic [WIN-1:0]   enc_vec_i,
  output logic [OFS_W-1:0] enc_ofs_o
);

  localparam logic [OFS_W-1:0] c_win = OFS_W'(WIN);
  localparam logic [OFS_W-1:0] c_one = OFS_W'(1);

  logic [DW-1:0]    win_q [WIN];
  logic [OFS_W-1:0] cnt_q;   // symbols of the current block held, saturating

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIN; k++) win_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      if (shift_i) begin
        win_q[0] <= sym_i;
        for (int k = 1; k < WIN; k++) win_q[k] <= win_q[k-1];
      end
      if (clear_i) begin
        cnt_q <= '0;
      end else if (shift_i && (cnt_q != c_win)) begin
        cnt_q <= cnt_q + c_one;
      end
    end
  end

  // Distance d is only eligible once d symbols of this block are stored, so
  // stale data from a previous block never matches.
  generate
    for (genvar d = 1; d <= WIN; d++) begin : g_cmp
      assign eq_o[d-1] = (cnt_q >= OFS_W'(d)) && (win_q[d-1] == sym_i);
    end
  endgenerate

  always_comb begin
    enc_ofs_o = '0;
    for (int k = WIN - 1; k >= 0; k--) begin
      if (enc_vec_i[k]) enc_ofs_o = OFS_W'(k + 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lz77_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : lz77_stream_encoder
//  Purpose  : LZ77 encoder. Consumes a ready/valid symbol stream delimited by
//             i_last and emits literal or (offset,length) tokens on a
//             ready/valid output, then pulses finish once per block.
//  Ports    : clk, rst       clock, async active-high reset
//             i_valid/i_ready/i_data/i_last   symbol input
//             o_valid/o_ready                 token handshake
//             o_is_match, o_literal, o_offset, o_length, o_last  token
//             finish         one-cycle pulse after the o_last handshake
//  Revision : 1.0  initial release
// ============================================================================
module lz77_stream_encoder
  import lz77_pkg::*;
#(
  parameter  int DW        = 8,
  parameter  int WIN       = 16,
  parameter  int MAX_LEN   = 15,
  parameter  int MIN_MATCH = 3,
  localparam int OFS_W     = ofs_width(WIN),
  localparam int LEN_W     = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [DW-1:0]    i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_match,
  output logic [DW-1:0]    o_literal,
  output logic [OFS_W-1:0] o_offset,
  output logic [LEN_W-1:0] o_length,
  output logic             o_last,
  output logic             finish
);

  localparam int P_D  = buf_depth(MIN_MATCH);
  localparam int PI_W = (P_D > 1) ? $clog2(P_D) : 1;

  localparam logic [LEN_W-1:0] c_one       = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_max_len   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_min_match = LEN_W'(MIN_MATCH);
  localparam logic [LEN_W-1:0] c_push_lim  = LEN_W'(MIN_MATCH - 1);

  typedef struct packed {
    logic             is_match;
    logic [DW-1:0]    literal;
    logic [OFS_W-1:0] offset;
    logic [LEN_W-1:0] length;
    logic             last;
  } token_t;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;          // current run length L
  logic [WIN-1:0]   m_q, m_d;              // surviving distances M
  logic [DW-1:0]    p_q [P_D];             // first symbols of a short run
  logic [DW-1:0]    p_d [P_D];
  logic [DW-1:0]    hold_c_q, hold_c_d;    // symbol that broke the run
  logic             hold_last_q, hold_last_d;
  logic [PI_W-1:0]  drain_idx_q, drain_idx_d;
  logic             drain_last_q, drain_last_d;
  token_t           tok_q, tok_d;
  logic             o_valid_q, o_valid_d;

  logic             w_out_free;
  logic [DW-1:0]    w_sym;
  logic             w_sym_last;
  logic             w_proc;
  logic [WIN-1:0]   w_e;
  logic [WIN-1:0]   w_m_and_e;
  logic             w_ext;
  logic [WIN-1:0]   w_enc_vec;
  logic [OFS_W-1:0] w_enc_ofs;
  logic [LEN_W-1:0] w_run_len;
  logic             w_drain_final;
  logic             w_shift;
  logic             w_clear;
  logic             w_close;
  logic             w_close_last;

  assign w_out_free = !o_valid_q || o_ready;
  assign i_ready    = !rst && (state_q == S_SCAN) && w_out_free;

  // In REEVAL the held breaking symbol is processed exactly like a fresh
  // accept; the window was not shifted for it, so its E vector is unchanged.
  assign w_sym      = (state_q == S_REEVAL) ? hold_c_q    : i_data;
  assign w_sym_last = (state_q == S_REEVAL) ? hold_last_q : i_last;
  assign w_proc     = ((state_q == S_SCAN) && i_valid && i_ready) ||
                      ((state_q == S_REEVAL) && w_out_free);

  assign w_m_and_e  = m_q & w_e;
  assign w_ext      = (len_q != '0) && (|w_m_and_e) && (len_q < c_max_len);

  // Run being closed: a new 1-symbol run, an extended run, or the run as-is.
  assign w_enc_vec  = (len_q == '0) ? w_e : (w_ext ? w_m_and_e : m_q);
  assign w_run_len  = (len_q == '0) ? c_one : (w_ext ? len_q + c_one : len_q);

  assign w_drain_final = ((LEN_W'(drain_idx_q) + c_one) == len_q);

  lz77_match_cam #(
    .DW    (DW),
    .WIN   (WIN),
    .OFS_W (OFS_W)
  ) u_cam (
    .clk       (clk),
    .rst       (rst),
    .shift_i   (w_shift),
    .clear_i   (w_clear),
    .sym_i     (w_sym),
    .eq_o      (w_e),
    .enc_vec_i (w_enc_vec),
    .enc_ofs_o (w_enc_ofs)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    m_d          = m_q;
    p_d          = p_q;
    hold_c_d     = hold_c_q;
    hold_last_d  = hold_last_q;
    drain_idx_d  = drain_idx_q;
    drain_last_d = drain_last_q;
    tok_d        = tok_q;
    o_valid_d    = o_valid_q && !o_ready;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_close      = 1'b0;
    w_close_last = 1'b0;

    unique case (state_q)
      S_SCAN, S_REEVAL: begin
        if (w_proc) begin
          if ((len_q == '0) && !(|w_e)) begin
            // No history hit: plain literal.
            w_shift       = 1'b1;
            tok_d         = '0;
            tok_d.literal = w_sym;
            tok_d.last    = w_sym_last;
            o_valid_d     = 1'b1;
            state_d       = w_sym_last ? S_FLUSH : S_SCAN;
          end else if ((len_q == '0) || w_ext) begin
            // Start or extend a run; no token yet.
            w_shift = 1'b1;
            len_d   = w_run_len;
            if (len_q == '0) begin
              m_d    = w_e;
              p_d[0] = w_sym;
            end else begin
              m_d = w_m_and_e;
              if (len_q < c_push_lim) p_d[PI_W'(len_q)] = w_sym;
            end
            if (w_sym_last) begin
              w_close      = 1'b1;
              w_close_last = 1'b1;
            end else begin
              state_d = S_SCAN;
            end
          end else begin
            // Run broken: close it and keep the symbol for re-evaluation.
            hold_c_d    = w_sym;
            hold_last_d = w_sym_last;
            w_close     = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (w_out_free) begin
          tok_d         = '0;
          tok_d.literal = p_q[drain_idx_q];
          o_valid_d     = 1'b1;
          drain_idx_d   = drain_idx_q + PI_W'(1);
          if (w_drain_final) begin
            tok_d.last = drain_last_q;
            len_d      = '0;
            m_d        = '0;
            state_d    = drain_last_q ? S_FLUSH : S_REEVAL;
          end
        end
      end

      S_FLUSH: begin
        if (w_out_free) state_d = S_FIN;
      end

      S_FIN: begin
        w_clear = 1'b1;
        len_d   = '0;
        m_d     = '0;
        state_d = S_SCAN;
      end

      default: state_d = S_SCAN;
    endcase

    if (w_close) begin
      if (w_run_len >= c_min_match) begin
        tok_d          = '0;
        tok_d.is_match = 1'b1;
        tok_d.offset   = w_enc_ofs;
        tok_d.length   = w_run_len;
        tok_d.last     = w_close_last;
        o_valid_d      = 1'b1;
        len_d          = '0;
        m_d            = '0;
        state_d        = w_close_last ? S_FLUSH : S_REEVAL;
      end else begin
        // len_d already holds the short run length; replay it from P.
        drain_idx_d  = '0;
        drain_last_d = w_close_last;
        state_d      = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SCAN;
      len_q        <= '0;
      m_q          <= '0;
      for (int k = 0; k < P_D; k++) p_q[k] <= '0;
      hold_c_q     <= '0;
      hold_last_q  <= 1'b0;
      drain_idx_q  <= '0;
      drain_last_q <= 1'b0;
      tok_q        <= '0;
      o_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      m_q          <= m_d;
      p_q          <= p_d;
      hold_c_q     <= hold_c_d;
      hold_last_q  <= hold_last_d;
      drain_idx_q  <= drain_idx_d;
      drain_last_q <= drain_last_d;
      tok_q        <= tok_d;
      o_valid_q    <= o_valid_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_is_match = tok_q.is_match;
  assign o_literal  = tok_q.literal;
  assign o_offset   = tok_q.offset;
  assign o_length   = tok_q.length;
  assign o_last     = tok_q.last;
  assign finish     = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_lz77_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lz77_stream_encoder
//  Purpose  : Directed self-checking bench for lz77_stream_encoder
//             (DW=8, WIN=16, MAX_LEN=8, MIN_MATCH=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lz77_stream_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_valid;
  logic       o_ready = 1'b1;
  logic       o_is_match;
  logic [7:0] o_literal;
  logic [4:0] o_offset;
  logic [3:0] o_length;
  logic       o_last;
  logic       finish;

  lz77_stream_encoder #(
    .DW        (8),
    .WIN       (16),
    .MAX_LEN   (8),
    .MIN_MATCH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_is_match (o_is_match),
    .o_literal  (o_literal),
    .o_offset   (o_offset),
    .o_length   (o_length),
    .o_last     (o_last),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          fin_cnt  = 0;
  int          fin_cyc  = 0;
  int          last_cyc = 0;
  int          stab_err = 0;
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_tok   = '0;
  logic [18:0] got_q [$];
  logic [18:0] exp_q [$];
  logic [7:0]  stim_q [$];
  logic [18:0] w_tok;

  assign w_tok = {o_is_match, o_literal, o_offset, o_length, o_last};

  function automatic logic [18:0] lit(input logic [7:0] d, input logic l);
    return {1'b0, d, 5'd0, 4'd0, l};
  endfunction

  function automatic logic [18:0] mat(input logic [4:0] ofs, input logic [3:0] len,
                                      input logic l);
    return {1'b1, 8'd0, ofs, len, l};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Token capture, finish timing and stall-stability observation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(o_valid && (w_tok == prev_tok))) stab_err++;
        prev_stall = o_valid && !o_ready;
        prev_tok   = w_tok;
        if (o_valid && o_ready) begin
          got_q.push_back(w_tok);
          if (o_last) last_cyc = cyc;
        end
        if (finish) begin
          fin_cnt++;
          fin_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int   t  = 0;
    logic ok = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    while (!ok && t < 500) begin
      @(negedge clk);
      if (i_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!ok) chk("send_accept", {31'd0, i_ready}, 32'd1);
  endtask

  task automatic run_block(input string tag);
    int fin_before;
    int t;
    fin_before = fin_cnt;
    got_q.delete();
    for (int i = 0; i < stim_q.size(); i++) send(stim_q[i], i == stim_q.size() - 1);
    t = 0;
    while (fin_cnt == fin_before && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_finish_count"}, 32'(fin_cnt - fin_before), 32'd1);
    chk({tag, "_ntok"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_tok%0d", tag, i),
          (i < got_q.size()) ? {13'd0, got_q[i]} : 32'hxxxx_xxxx, {13'd0, exp_q[i]});
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_finish",  {31'd0, finish},  32'd0);
    chk("rst_token",   {13'd0, w_tok},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: all literals, finish one cycle after the o_last handshake
    stim_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    exp_q  = '{lit(8'h00, 0), lit(8'h01, 0), lit(8'h02, 0), lit(8'h03, 1)};
    run_block("t1");
    chk("t1_finish_delay", 32'(fin_cyc - last_cyc), 32'd1);

    // 2: repeated triple becomes one overlapping match of length 6
    stim_q = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
    exp_q  = '{lit(8'h41, 0), lit(8'h42, 0), lit(8'h43, 0), mat(5'd3, 4'd6, 1)};
    run_block("t2");

    // 3: sixteen identical symbols, split at MAX_LEN
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'h07);
    exp_q = '{lit(8'h07, 0), mat(5'd1, 4'd8, 0), mat(5'd1, 4'd7, 1)};
    run_block("t3");

    // 4: two-symbol run below MIN_MATCH is drained as literals
    stim_q = '{8'h01, 8'h02, 8'h09, 8'h01, 8'h02, 8'h05};
    exp_q  = '{lit(8'h01, 0), lit(8'h02, 0), lit(8'h09, 0),
               lit(8'h01, 0), lit(8'h02, 0), lit(8'h05, 1)};
    run_block("t4");

    // 5: block 2 again under random backpressure
    stab_err   = 0;
    rand_ready = 1'b1;
    stim_q = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
    exp_q  = '{lit(8'h41, 0), lit(8'h42, 0), lit(8'h43, 0), mat(5'd3, 4'd6, 1)};
    run_block("t5");
    chk("t5_stable_while_stalled", 32'(stab_err), 32'd0);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // 6: asynchronous reset in the middle of a run, then a fresh block
    for (int i = 0; i < 5; i++) send(8'h07, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("t6_rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("t6_rst_finish",  {31'd0, finish},  32'd0);
    chk("t6_rst_token",   {13'd0, w_tok},   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    stim_q = '{8'h07, 8'h07};
    exp_q  = '{lit(8'h07, 0), lit(8'h07, 1)};
    run_block("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
